// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants: reset vector, NOP encoding,
// fetch FSM state encoding and the PC increment helper.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_REQ    = 2'd0,
        FS_WAIT   = 2'd1,
        FS_HOLD   = 2'd2,
        FS_CANCEL = 2'd3
    } fetch_state_e;

    // Modulo-2^32 increment, so 32'hFFFFFFFC wraps to 0.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction SRAM-like port: single request/response handshake between
// the fetch stage (master) and the instruction memory (slave).
interface inst_fetch_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );

endinterface

// File: rtl/inst_hold_buf.sv
// One-entry instruction/PC buffer that parks a returned instruction while
// the decode stage is stalled.
module inst_hold_buf
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_inst,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [31:0] inst,
    output logic [31:0] pc
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= load_inst;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC generation, single-outstanding fetch handshake
// and IF/ID presentation. `define FETCH_ADEL_CHECK_EN adds the if_adel output.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   FS_REQ    | request pc on the bus (or present an ADEL bubble if misaligned)
//   FS_WAIT   | request accepted, waiting for the response
//   FS_HOLD   | response captured in the hold buffer while ID stalls
//   FS_CANCEL | flushed with a response still in flight; drop it
module inst_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if_id,
    input  logic        flush_if_id,
    input  logic [31:0] flush_target,
    input  logic        branch_redirect,
    input  logic [31:0] branch_target,
    inst_fetch_if.master mem,
    output logic [31:0] if_inst,
    output logic [31:0] if_cur_instaddress,
    output logic [31:0] if_next_instaddress
`ifdef FETCH_ADEL_CHECK_EN
    ,
    output logic        if_adel
`endif
);

    fetch_state_e state, state_nxt;

    logic [31:0] pc;
    logic        pend_valid;
    logic [31:0] pend_target;

    logic        buf_valid;
    logic [31:0] buf_inst;
    logic [31:0] buf_pc;
    logic        buf_load;
    logic        buf_clear;

    logic        pc_misaligned;
    logic        inst_valid;
    logic [31:0] inst_word;
    logic [31:0] inst_pc;
    logic        accept;
    logic        show;

`ifdef FETCH_ADEL_CHECK_EN
    assign pc_misaligned = (pc[1:0] != 2'b00);
`else
    assign pc_misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FS_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush_if_id) begin
            case (state)
                FS_REQ:    state_nxt = (mem.inst_req && mem.inst_addr_ok) ? FS_CANCEL : FS_REQ;
                FS_WAIT,
                FS_CANCEL: state_nxt = mem.inst_data_ok ? FS_REQ : FS_CANCEL;
                default:   state_nxt = FS_REQ;
            endcase
        end else begin
            case (state)
                FS_REQ:    if (mem.inst_req && mem.inst_addr_ok) state_nxt = FS_WAIT;
                FS_WAIT:   if (mem.inst_data_ok) state_nxt = stall_if_id ? FS_HOLD : FS_REQ;
                FS_HOLD:   if (!stall_if_id) state_nxt = FS_REQ;
                FS_CANCEL: if (mem.inst_data_ok) state_nxt = FS_REQ;
                default:   state_nxt = FS_REQ;
            endcase
        end
    end

    always_comb begin
        mem.inst_req = 1'b0;
        inst_valid   = 1'b0;
        inst_word    = NOP_INST;
        inst_pc      = pc;
        buf_load     = 1'b0;
        case (state)
            FS_REQ: begin
                // A misaligned PC never reaches the bus; it retires as a NOP.
                if (pc_misaligned) begin
                    inst_valid = 1'b1;
                end else begin
                    mem.inst_req = 1'b1;
                end
            end
            FS_WAIT: begin
                inst_valid = mem.inst_data_ok;
                inst_word  = mem.inst_rdata;
                buf_load   = mem.inst_data_ok && stall_if_id && !flush_if_id;
            end
            FS_HOLD: begin
                inst_valid = buf_valid;
                inst_word  = buf_inst;
                inst_pc    = buf_pc;
            end
            default: ;
        endcase
    end

    assign mem.inst_addr = pc;

    assign accept    = inst_valid && !stall_if_id && !flush_if_id;
    assign buf_clear = flush_if_id || ((state == FS_HOLD) && accept);

    inst_hold_buf u_hold_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .clear     (buf_clear),
        .load_inst (mem.inst_rdata),
        .load_pc   (pc),
        .valid     (buf_valid),
        .inst      (buf_inst),
        .pc        (buf_pc)
    );

    // pc only moves on accept, so it is always the address of the presented word.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else if (flush_if_id) begin
            pc         <= flush_target;
            pend_valid <= 1'b0;
        end else if (accept) begin
            pc         <= pend_valid      ? pend_target   :
                          branch_redirect ? branch_target : pc_plus4(pc);
            pend_valid <= 1'b0;
        end else if (branch_redirect) begin
            pend_valid  <= 1'b1;
            pend_target <= branch_target;
        end
    end

    assign show                = inst_valid && !flush_if_id && !rst;
    assign if_inst             = show ? inst_word : NOP_INST;
    assign if_cur_instaddress  = show ? inst_pc : 32'h0;
    assign if_next_instaddress = show ? pc_plus4(inst_pc) : 32'h0;

`ifdef FETCH_ADEL_CHECK_EN
    assign if_adel = show && (state == FS_REQ) && pc_misaligned;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a bus slave with configurable wait states, and a
// scoreboard of expected request addresses and delivered instructions.
module tb_inst_fetch;
    import cpu_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] nxt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_if_id = 1'b0;
    logic        flush_if_id = 1'b0;
    logic [31:0] flush_target = 32'h0;
    logic        branch_redirect = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] if_inst;
    logic [31:0] if_cur_instaddress;
    logic [31:0] if_next_instaddress;
`ifdef FETCH_ADEL_CHECK_EN
    logic        if_adel;
`endif

    inst_fetch_if bus ();

    inst_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall_if_id         (stall_if_id),
        .flush_if_id         (flush_if_id),
        .flush_target        (flush_target),
        .branch_redirect     (branch_redirect),
        .branch_target       (branch_target),
        .mem                 (bus),
        .if_inst             (if_inst),
        .if_cur_instaddress  (if_cur_instaddress),
        .if_next_instaddress (if_next_instaddress)
`ifdef FETCH_ADEL_CHECK_EN
        ,
        .if_adel             (if_adel)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 1'b0;

    logic [31:0] exp_req_q[$];
    exp_t        exp_inst_q[$];
    exp_t        e;
    logic [31:0] ea;

    int          addr_wait = 0;
    int          data_delay = 0;
    bit          outst = 1'b0;
    bit          acc_prev = 1'b0;
    bit          dok_prev = 1'b0;
    logic [31:0] outst_addr = 32'h0;
    logic [31:0] prev_addr = 32'h0;
    int          dcnt = 0;
    int          awc = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Slave: decides handshakes at the falling edge from the registered request.
    initial begin
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (rst) begin
                outst = 1'b0; acc_prev = 1'b0; dok_prev = 1'b0; awc = 0;
                bus.inst_addr_ok = 1'b0;
                bus.inst_data_ok = 1'b0;
                bus.inst_rdata   = 32'hDEAD_BEEF;
            end else begin
                if (dok_prev) outst = 1'b0;
                if (acc_prev) begin
                    outst = 1'b1; outst_addr = prev_addr; dcnt = data_delay;
                end
                bus.inst_data_ok = outst && (dcnt == 0);
                bus.inst_rdata   = bus.inst_data_ok ? mem_word(outst_addr) : 32'hDEAD_BEEF;
                if (outst && dcnt > 0) dcnt--;
                if (bus.inst_req && awc < addr_wait) begin
                    bus.inst_addr_ok = 1'b0;
                    awc++;
                end else begin
                    bus.inst_addr_ok = bus.inst_req;
                end
                acc_prev = bus.inst_req && bus.inst_addr_ok;
                if (acc_prev) awc = 0;
                prev_addr = bus.inst_addr;
                dok_prev  = bus.inst_data_ok;
            end
        end
    end

    // Scoreboard: pop on every bus request handshake and every IF/ID accept.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en && !rst) begin
                if (bus.inst_req && bus.inst_addr_ok) begin
                    if (exp_req_q.size() > 0) begin
                        ea = exp_req_q.pop_front();
                        check_val("req_addr", bus.inst_addr, ea);
                    end else begin
                        check_val("req_unexp", bus.inst_addr, 32'h1);
                    end
                end
                if (if_cur_instaddress != 32'h0 && !stall_if_id && !flush_if_id) begin
                    if (exp_inst_q.size() > 0) begin
                        e = exp_inst_q.pop_front();
                        check_val("if_cur", if_cur_instaddress, e.pc);
                        check_val("if_inst", if_inst, e.inst);
                        check_val("if_next", if_next_instaddress, e.nxt);
                    end else begin
                        check_val("inst_unexp", if_cur_instaddress, 32'h0);
                    end
                end
            end
        end
    end

    task automatic push_req(input logic [31:0] a);
        exp_req_q.push_back(a);
    endtask

    task automatic push_inst(input logic [31:0] a);
        exp_t x;
        x.pc = a; x.inst = mem_word(a); x.nxt = a + 32'd4;
        exp_inst_q.push_back(x);
    endtask

    task automatic begin_test(input int aw, input int dd);
        @(negedge clk);
        rst = 1'b1; mon_en = 1'b0;
        stall_if_id = 1'b0; flush_if_id = 1'b0; branch_redirect = 1'b0;
        addr_wait = aw; data_delay = dd;
        exp_req_q.delete(); exp_inst_q.delete();
        @(negedge clk);
        #1;
        check_val("rst_inst", if_inst, NOP_INST);
        check_val("rst_cur", if_cur_instaddress, 32'h0);
        check_val("rst_next", if_next_instaddress, 32'h0);
        check_val("rst_pc", bus.inst_addr, 32'hBFC0_0000);
    endtask

    task automatic release_rst(input bit mon);
        @(negedge clk);
        rst = 1'b0; mon_en = mon;
        #1;
        check_val("first_req", 32'(bus.inst_req), 32'd1);
        check_val("first_addr", bus.inst_addr, 32'hBFC0_0000);
    endtask

    task automatic wait_req(input logic [31:0] a);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            #1;
            if (bus.inst_req && bus.inst_addr_ok && bus.inst_addr == a) found = 1'b1;
        end
        check_val("wait_req", 32'(found), 32'd1);
    endtask

    task automatic finish_test();
        for (int i = 0; i < 300 && (exp_req_q.size() + exp_inst_q.size()) > 0; i++) begin
            @(negedge clk);
            #2;
        end
        check_val("drain", 32'(exp_req_q.size() + exp_inst_q.size()), 32'd0);
        mon_en = 1'b0;
    endtask

    initial begin
        // Straight-line fetch, zero-wait slave
        begin_test(0, 0);
        push_req(32'hBFC0_0000); push_req(32'hBFC0_0004); push_req(32'hBFC0_0008);
        push_inst(32'hBFC0_0000); push_inst(32'hBFC0_0004); push_inst(32'hBFC0_0008);
        release_rst(1'b1);
        finish_test();

        // Stall while the response for BFC00004 returns
        begin_test(0, 0);
        push_req(32'hBFC0_0000); push_req(32'hBFC0_0004); push_req(32'hBFC0_0008);
        push_inst(32'hBFC0_0000); push_inst(32'hBFC0_0004); push_inst(32'hBFC0_0008);
        release_rst(1'b1);
        wait_req(32'hBFC0_0004);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stall_if_id = 1'b1;
            #1;
            check_val("hold_cur", if_cur_instaddress, 32'hBFC0_0004);
            check_val("hold_inst", if_inst, mem_word(32'hBFC0_0004));
            check_val("hold_req", 32'(bus.inst_req), 32'd0);
        end
        @(negedge clk);
        stall_if_id = 1'b0;
        finish_test();

        // Redirect during WAIT of the delay slot, overwritten once
        begin_test(0, 2);
        push_req(32'hBFC0_0000); push_req(32'hBFC0_0004); push_req(32'hBFC0_0008);
        push_req(32'hBFC0_000C); push_req(32'hBFC0_0100);
        push_inst(32'hBFC0_0000); push_inst(32'hBFC0_0004); push_inst(32'hBFC0_0008);
        push_inst(32'hBFC0_000C); push_inst(32'hBFC0_0100);
        release_rst(1'b1);
        wait_req(32'hBFC0_000C);
        @(negedge clk);
        branch_redirect = 1'b1; branch_target = 32'hBFC0_0200;
        @(negedge clk);
        branch_target = 32'hBFC0_0100;
        @(negedge clk);
        branch_redirect = 1'b0;
        finish_test();

        // Flush in WAIT drops the stale response and the pending redirect
        begin_test(0, 2);
        push_req(32'hBFC0_0000); push_req(32'hBFC0_0004); push_req(32'hBFC0_0008);
        push_req(32'hBFC0_0380); push_req(32'hBFC0_0384);
        push_inst(32'hBFC0_0000); push_inst(32'hBFC0_0004);
        push_inst(32'hBFC0_0380); push_inst(32'hBFC0_0384);
        release_rst(1'b1);
        wait_req(32'hBFC0_0008);
        @(negedge clk);
        branch_redirect = 1'b1; branch_target = 32'hBFC0_0300;
        @(negedge clk);
        branch_redirect = 1'b0;
        flush_if_id = 1'b1; flush_target = 32'hBFC0_0380;
        @(negedge clk);
        flush_if_id = 1'b0;
        #1;
        check_val("cancel_data_ok", 32'(bus.inst_data_ok), 32'd1);
        check_val("cancel_cur", if_cur_instaddress, 32'h0);
        check_val("cancel_inst", if_inst, NOP_INST);
        finish_test();

        // Flush and redirect together while data returns: flush wins
        begin_test(0, 0);
        push_req(32'hBFC0_0000); push_req(32'hBFC0_0004);
        push_req(32'hBFC0_0500); push_req(32'hBFC0_0504);
        push_inst(32'hBFC0_0000); push_inst(32'hBFC0_0500); push_inst(32'hBFC0_0504);
        release_rst(1'b1);
        wait_req(32'hBFC0_0004);
        @(negedge clk);
        flush_if_id = 1'b1; flush_target = 32'hBFC0_0500;
        branch_redirect = 1'b1; branch_target = 32'hBFC0_0600;
        #1;
        check_val("flush_cur", if_cur_instaddress, 32'h0);
        check_val("flush_inst", if_inst, NOP_INST);
        @(negedge clk);
        flush_if_id = 1'b0; branch_redirect = 1'b0;
        finish_test();

        // Address wait states: request held stable until accepted
        begin_test(2, 0);
        push_req(32'hBFC0_0000); push_req(32'hBFC0_0004);
        push_inst(32'hBFC0_0000); push_inst(32'hBFC0_0004);
        release_rst(1'b1);
        @(negedge clk);
        #1;
        check_val("stable_req", 32'(bus.inst_req), 32'd1);
        check_val("stable_addr", bus.inst_addr, 32'hBFC0_0000);
        finish_test();

        // Flush from REQ with addr_ok, then PC wrap at the top of memory
        begin_test(0, 0);
        push_req(32'hBFC0_0000); push_req(32'hBFC0_0004);
        push_req(32'hFFFF_FFFC); push_req(32'h0000_0000);
        push_inst(32'hBFC0_0000); push_inst(32'hFFFF_FFFC);
        release_rst(1'b1);
        wait_req(32'hBFC0_0000);
        @(negedge clk);
        @(negedge clk);
        flush_if_id = 1'b1; flush_target = 32'hFFFF_FFFC;
        @(negedge clk);
        flush_if_id = 1'b0;
        #1;
        check_val("req_cancel_cur", if_cur_instaddress, 32'h0);
        finish_test();

`ifdef FETCH_ADEL_CHECK_EN
        // Misaligned flush target: no bus request, ADEL bubble presented
        begin_test(0, 0);
        release_rst(1'b0);
        wait_req(32'hBFC0_0000);
        @(negedge clk);
        @(negedge clk);
        flush_if_id = 1'b1; flush_target = 32'hBFC0_0382;
        @(negedge clk);
        flush_if_id = 1'b0;
        @(negedge clk);
        #1;
        check_val("adel_req", 32'(bus.inst_req), 32'd0);
        check_val("adel_flag", 32'(if_adel), 32'd1);
        check_val("adel_cur", if_cur_instaddress, 32'hBFC0_0382);
        check_val("adel_inst", if_inst, NOP_INST);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
